// File: rtl/racc_pkg.sv
// Shared definitions for the ripple accumulator.
// Holds the FSM state encoding and the default operand and counter widths.
package racc_pkg;

    localparam int unsigned RACC_WIDTH = 16;
    localparam int unsigned RACC_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } racc_state_t;

endpackage

// File: rtl/racc_add.sv
// Combinational WIDTH-bit ripple-carry adder, built from WIDTH/4 chained 4-bit slices.
// Ports: a, b  - operands
//        cin   - carry into the least-significant slice
//        sum   - WIDTH-bit result
//        cout  - carry out of the most-significant slice
module racc_add
    import racc_pkg::*;
#(
    parameter int unsigned WIDTH = RACC_WIDTH
) (
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin
);

    localparam int unsigned SLICES = WIDTH / 4;

    // Carry between slices; c[0] is the external carry-in.
    logic [SLICES:0] c;

    assign c[0] = cin;

    for (genvar s = 0; s < SLICES; s++) begin : g_slice
        // Carry chain internal to one 4-bit slice.
        logic [4:0] rc;
        assign rc[0] = c[s];
        for (genvar i = 0; i < 4; i++) begin : g_bit
            assign sum[4*s+i] = a[4*s+i] ^ b[4*s+i] ^ rc[i];
            assign rc[i+1]    = (a[4*s+i] & b[4*s+i]) | (rc[i] & (a[4*s+i] ^ b[4*s+i]));
        end
        assign c[s+1] = rc[4];
    end

    assign cout = c[SLICES];

endmodule

// File: rtl/ripple_accumulator.sv
// Multi-operand accumulator wrapped around a ripple-carry adder.
// Sums a packet of operands (terminated by in_last), tracks sticky unsigned
// carry-out and signed overflow, then holds the result on a valid/ready port.
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready/in_data/in_last - operand stream
//        clear                             - synchronous abort, highest priority
//        out_valid/out_ready               - result handshake
//        out_sum/out_carry/out_ovf/out_count - packet result
// Build option: define RACC_SAT_EN for unsigned saturation instead of wrap-around
// (out_ovf then reads 0).
module ripple_accumulator
    import racc_pkg::*;
#(
    parameter int unsigned WIDTH = RACC_WIDTH,
    parameter int unsigned CNT_W = RACC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

`ifdef RACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int unsigned MSB = WIDTH - 1;

    racc_state_t      state;
    logic             ovf_q;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic [WIDTH-1:0] acc_next_c;
    logic             accept_c;
    logic             ovf_step_c;

    // The running total (out_sum) is one adder operand, the new data the other.
    racc_add #(.WIDTH(WIDTH)) u_add (
        .sum  (sum_c),
        .cout (cout_c),
        .a    (out_sum),
        .b    (in_data),
        .cin  (1'b0)
    );

    assign accept_c   = in_valid && in_ready;
    assign ovf_step_c = (out_sum[MSB] == in_data[MSB]) && (sum_c[MSB] != out_sum[MSB]);
    // Saturating build pins the total at all ones once any add carries out.
    assign acc_next_c = (SAT_EN && cout_c) ? {WIDTH{1'b1}} : sum_c;
    assign out_ovf    = SAT_EN ? 1'b0 : ovf_q;

    // FSM, accumulator, sticky flags and saturating operand counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_sum   <= '0;
            out_carry <= 1'b0;
            ovf_q     <= 1'b0;
            out_count <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            out_sum   <= '0;
            out_carry <= 1'b0;
            ovf_q     <= 1'b0;
            out_count <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        out_sum   <= acc_next_c;
                        out_carry <= out_carry | cout_c;
                        ovf_q     <= ovf_q | ovf_step_c;
                        if (out_count != {CNT_W{1'b1}})
                            out_count <= out_count + CNT_W'(1);
                        if (in_last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_sum   <= '0;
                        out_carry <= 1'b0;
                        ovf_q     <= 1'b0;
                        out_count <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
